ahb_panel_master: RTL

Single-master AHB-Lite sequencer that turns the board's push-button/switch panel into bus transactions for the two 8-bit AHB slaves on the FPGA. It synchronises the confirm button, latches a command (slave, address, data, direction, burst), drives the shared address/control/write-data bus plus the two slave selects, tracks wait states and error responses, and returns read data and status for the seven-segment display path.

---
 rtl/ahb_panel_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_panel_master.sv
// ahb_panel_master: turns the push-button panel into AHB-Lite transfers on two 8-bit slaves.
// Define PANEL_BURST_EN to honour cmd_burst (INCR4); otherwise every transfer is SINGLE.
module ahb_panel_master (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       confirm,
  input  logic       cmd_write,
  input  logic       cmd_slave,
  input  logic       cmd_burst,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       hsel_1,
  output logic       hsel_2,
  output logic [9:0] haddr,
  output logic       hwrite,
  output logic [2:0] hburst,
  output logic [1:0] htrans,
  output logic [7:0] hwdata,
  input  logic       hreadyout_1,
  input  logic       hreadyout_2,
  input  logic       hresp_1,
  input  logic       hresp_2,
  input  logic [7:0] hrdata_1,
  input  logic [7:0] hrdata_2,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [7:0] rsum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_BEAT = 3'd2,
    S_LAST = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q, edge_q;
  logic       start, accept;
  logic       cwrite_q, cslave_q;
  logic [9:0] caddr_q;
  logic [7:0] cwdata_q;
  logic       hready, hresp;
  logic [7:0] hrdata;
  logic       burst;
  logic [1:0] beat;
  logic       data_done;
  logic       done_q, done_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d, rsum_q, rsum_d;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= confirm;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign start  = sync2_q & ~edge_q;
  assign accept = start && (state_q == S_IDLE);

  assign hready = cslave_q ? hreadyout_2 : hreadyout_1;
  assign hresp  = cslave_q ? hresp_2     : hresp_1;
  assign hrdata = cslave_q ? hrdata_2    : hrdata_1;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cwrite_q <= 1'b0;
      cslave_q <= 1'b0;
      caddr_q  <= '0;
      cwdata_q <= '0;
    end else if (accept) begin
      cwrite_q <= cmd_write;
      cslave_q <= cmd_slave;
      caddr_q  <= cmd_addr;
      cwdata_q <= cmd_wdata;
    end
  end

`ifdef PANEL_BURST_EN
  logic       cburst_q;
  logic [1:0] beat_q, beat_d;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cburst_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      if (accept) cburst_q <= cmd_burst;
      beat_q <= beat_d;
    end
  end

  // beat counts completed data phases; it ends at 3 so LAST/ERR still know the final index
  always_comb begin
    beat_d = beat_q;
    if (accept)
      beat_d = '0;
    else if (state_q == S_BEAT && hready)
      beat_d = beat_q + 2'd1;
  end

  assign burst  = cburst_q;
  assign beat   = beat_q;
  assign hburst = cburst_q ? 3'b011 : 3'b000;
`else
  logic unused_burst;
  assign unused_burst = cmd_burst;
  assign burst        = 1'b0;
  assign beat         = '0;
  assign hburst       = 3'b000;
`endif

  assign data_done = hready && ((state_q == S_BEAT) || (state_q == S_LAST && !hresp));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    rsum_d  = rsum_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ADDR;
        err_d   = 1'b0;
        rsum_d  = '0;
      end
      S_ADDR: if (hready) state_d = burst ? S_BEAT : S_LAST;
`ifdef PANEL_BURST_EN
      S_BEAT: begin
        if (!hready && hresp)
          state_d = S_ERR;
        else if (hready && beat == 2'd2)
          state_d = S_LAST;
      end
`endif
      S_LAST: begin
        if (!hready && hresp) begin
          state_d = S_ERR;
        end else if (hready && !hresp) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERR: if (hready) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (data_done && !cwrite_q) begin
      rdata_d = hrdata;
      rsum_d  = rsum_q + hrdata;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rsum_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rsum_q  <= rsum_d;
    end
  end

  // in BEAT the bus carries beat k+1's address while beat k's data is in flight
  always_comb begin
    htrans = 2'b00;
    haddr  = '0;
    hwdata = '0;
    case (state_q)
      S_ADDR: begin
        htrans = 2'b10;
        haddr  = caddr_q;
      end
      S_BEAT: begin
        htrans = 2'b11;
        haddr  = caddr_q + {8'd0, beat} + 10'd1;
      end
      S_LAST, S_ERR: haddr = caddr_q + {8'd0, beat};
      default: ;
    endcase
    if (cwrite_q && (state_q == S_BEAT || state_q == S_LAST))
      hwdata = cwdata_q + {6'd0, beat};
  end

  assign busy   = (state_q != S_IDLE);
  assign hsel_1 = busy && !cslave_q;
  assign hsel_2 = busy && cslave_q;
  assign hwrite = busy && cwrite_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign rsum   = rsum_q;

endmodule
